// File: rtl/ddram_wr_buffer_pkg.sv
// ddram_wr_buffer_pkg
//   Shared types and constants for the DDRAM write buffer.
//   wr_entry_t : one queued DDRAM beat {addr[28:0], data[63:0], be[7:0]}.
//   BURSTCNT_ONE : single-beat burst count driven to the arbiter.
package ddram_wr_buffer_pkg;

  localparam logic [7:0] BURSTCNT_ONE = 8'd1;

  typedef struct packed {
    logic [28:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
  } wr_entry_t;

endpackage

// File: rtl/ddram_wr_fifo.sv
// ddram_wr_fifo
//   Generic synchronous FIFO. The storage array has no reset, so it can map
//   onto block RAM. The read port is registered: o_rdata loads the head entry
//   on a pop and holds it otherwise.
//   Ports:
//     i_clk, i_rst_n      clock, asynchronous active-low reset
//     i_push, i_wdata     write request and data (ignored when full and no pop)
//     i_pop               read request (ignored when empty)
//     o_rdata             registered read data, valid the cycle after a pop
//     o_full, o_empty     occupancy flags
//     o_level             occupancy, 0 .. 2**DEPTH_LOG2
module ddram_wr_fifo #(
  parameter int WIDTH      = 101,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [WIDTH-1:0]      r_rdata;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_rdata;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // accepted then. When full, wr_ptr == rd_ptr: the read below sees the old
  // head entry because the write lands at the same edge.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (w_do_pop) begin
      r_rdata <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ddram_wr_buffer.sv
// ddram_wr_buffer
//   Write buffer between the screen rotator's single-beat DDRAM write port and
//   the DDRAM arbiter. Writes are taken every cycle regardless of DDRAM_BUSY,
//   half-word writes to the same 64-bit word are merged in a staging register,
//   and merged beats are queued and replayed honouring DDRAM_BUSY.
//   Ports:
//     CLK_VIDEO, reset_n            clock, asynchronous active-low reset
//     in_we/in_addr/in_din/in_be    rotator write beat
//     flush                         push the staged word now
//     DDRAM_*                       MiSTer DDRAM write port (RD tied low)
//     overflow                      sticky: a word was dropped on a full FIFO
//     level                         FIFO occupancy
module ddram_wr_buffer
  import ddram_wr_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5,
  parameter int IDLE_FLUSH = 8
) (
  input  logic                CLK_VIDEO,
  input  logic                reset_n,
  input  logic                in_we,
  input  logic [28:0]         in_addr,
  input  logic [63:0]         in_din,
  input  logic [7:0]          in_be,
  input  logic                flush,
  output logic                DDRAM_CLK,
  input  logic                DDRAM_BUSY,
  output logic [7:0]          DDRAM_BURSTCNT,
  output logic [28:0]         DDRAM_ADDR,
  output logic [63:0]         DDRAM_DIN,
  output logic [7:0]          DDRAM_BE,
  output logic                DDRAM_WE,
  output logic                DDRAM_RD,
  output logic                overflow,
  output logic [DEPTH_LOG2:0] level
);

  localparam int EW = $bits(wr_entry_t);
  // Counter value seen on the last of IDLE_FLUSH idle cycles.
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_FLUSH - 1);

  logic        r_stg_valid;
  logic [28:0] r_stg_addr;
  logic [63:0] r_stg_data;
  logic [7:0]  r_stg_be;
  logic [7:0]  r_idle_cnt;
  logic        r_out_we;
  logic        r_overflow;

  logic [63:0] w_merged_data;
  logic        w_merge;
  logic        w_push;
  logic        w_pop;
  logic        w_idle_hit;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [EW-1:0] w_fifo_rdata;
  wr_entry_t   w_push_entry;
  wr_entry_t   w_out;

  assign DDRAM_CLK      = CLK_VIDEO;
  assign DDRAM_BURSTCNT = BURSTCNT_ONE;
  assign DDRAM_RD       = 1'b0;

  // Byte-wise merge of the incoming beat over the staged word.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      assign w_merged_data[gi*8 +: 8] = in_be[gi] ? in_din[gi*8 +: 8]
                                                  : r_stg_data[gi*8 +: 8];
    end
  endgenerate

  // Merge only into the staged word, only on a matching address with disjoint
  // byte enables, and never when flush asks for the staged word to be closed.
  assign w_merge    = in_we & r_stg_valid & ~flush & (in_addr == r_stg_addr) &
                      ~(|(in_be & r_stg_be));
  assign w_idle_hit = r_stg_valid & (r_idle_cnt >= IDLE_LAST);
  assign w_push     = r_stg_valid & (in_we ? ~w_merge : (flush | w_idle_hit));

  assign w_push_entry = '{addr: r_stg_addr, data: r_stg_data, be: r_stg_be};

  always_ff @(posedge CLK_VIDEO or negedge reset_n) begin
    if (!reset_n) begin
      r_stg_valid <= 1'b0;
      r_stg_addr  <= '0;
      r_stg_data  <= '0;
      r_stg_be    <= '0;
      r_idle_cnt  <= '0;
    end else if (in_we) begin
      r_stg_valid <= 1'b1;
      r_stg_addr  <= in_addr;
      r_stg_data  <= w_merge ? w_merged_data : in_din;
      r_stg_be    <= w_merge ? (r_stg_be | in_be) : in_be;
      r_idle_cnt  <= '0;
    end else if (w_push) begin
      r_stg_valid <= 1'b0;
      r_idle_cnt  <= '0;
    end else if (r_stg_valid && r_idle_cnt != 8'hFF) begin
      r_idle_cnt  <= r_idle_cnt + 8'd1;
    end
  end

  // Refill the output register whenever it is empty or being accepted now,
  // which gives back-to-back beats without a bubble.
  assign w_pop = ~w_fifo_empty & (~r_out_we | ~DDRAM_BUSY);

  ddram_wr_fifo #(
    .WIDTH      (EW),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (CLK_VIDEO),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (level)
  );

  // The FIFO's registered read port doubles as the DDRAM output register.
  assign w_out      = wr_entry_t'(w_fifo_rdata);
  assign DDRAM_ADDR = w_out.addr;
  assign DDRAM_DIN  = w_out.data;
  assign DDRAM_BE   = w_out.be;
  assign DDRAM_WE   = r_out_we;
  assign overflow   = r_overflow;

  always_ff @(posedge CLK_VIDEO or negedge reset_n) begin
    if (!reset_n) begin
      r_out_we   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_out_we <= w_pop | (r_out_we & DDRAM_BUSY);
      // A dropped word is only one that meets a full FIFO with no pop freeing a slot.
      if (w_push && w_fifo_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
